// File: rtl/zero_cross_slicer.sv
// zero_cross_slicer: slices a signed sample stream into a hysteretic square
// wave (sigout) for the digital PLL, measures the CLK-cycle period between
// consecutive rising transitions, and flags loss of signal after TIMEOUT
// cycles without any transition.
module zero_cross_slicer #(
    parameter logic signed [15:0] HYST    = 16'sd256,
    parameter int unsigned        HOLDOFF = 8,
    parameter logic [19:0]        TIMEOUT = 20'd100000
) (
    input  logic               CLK,
    input  logic               RSTb,
    input  logic signed [15:0] sample_in,
    input  logic               sample_valid,
    output logic               sigout,
    output logic [19:0]        period,
    output logic               period_valid,
    output logic               no_signal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic signed [15:0] NEG_HYST     = -HYST;
    localparam logic [7:0]         HOLDOFF_LOAD = 8'(HOLDOFF);
    localparam logic [19:0]        CNT_MAX      = 20'hFFFFF;

    state_t      state;
    logic [7:0]  holdoff_cnt;
    logic [19:0] period_cnt;
    logic [19:0] idle_cnt;
    logic [19:0] idle_next;
    logic        armed;

    logic        above;
    logic        below;
    logic        go_high;
    logic        go_low;
    logic        timed_out;

    // Qualify the current sample and decide whether it moves the slicer.
    always_comb begin
        above   = sample_valid && (sample_in > HYST);
        below   = sample_valid && (sample_in < NEG_HYST);
        go_high = 1'b0;
        go_low  = 1'b0;
        case (state)
            // Leaving IDLE ignores holdoff: the first crossing is always taken.
            IDLE: begin
                go_high = above;
                go_low  = below;
            end
            HIGH:    go_low  = below && (holdoff_cnt == 8'd0);
            LOW:     go_high = above && (holdoff_cnt == 8'd0);
            default: ;
        endcase
        idle_next = (idle_cnt >= TIMEOUT) ? TIMEOUT : idle_cnt + 20'd1;
        timed_out = (idle_next == TIMEOUT);
    end

    // Slicer state machine, holdoff, period measurement and loss-of-signal.
    // NOTE: reset is sampled on the clock edge and every register here uses
    // non-blocking assignment so all updates see the pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            state        <= IDLE;
            sigout       <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            no_signal    <= 1'b1;
            holdoff_cnt  <= '0;
            period_cnt   <= '0;
            idle_cnt     <= '0;
            armed        <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (period_cnt != CNT_MAX) begin
                period_cnt <= period_cnt + 20'd1;
            end

            if (go_high || go_low) begin
                // A transition always beats a coincident timeout.
                state       <= go_high ? HIGH : LOW;
                sigout      <= go_high;
                holdoff_cnt <= HOLDOFF_LOAD;
                idle_cnt    <= '0;
                no_signal   <= 1'b0;
                if (go_high) begin
                    period_cnt <= 20'd1;
                    armed      <= 1'b1;
                    // Only a LOW->HIGH edge with a previous rise on record
                    // closes a full measured period.
                    if ((state == LOW) && armed) begin
                        period       <= period_cnt;
                        period_valid <= 1'b1;
                    end
                end
            end else begin
                if (sample_valid && (holdoff_cnt != 8'd0)) begin
                    holdoff_cnt <= holdoff_cnt - 8'd1;
                end
                idle_cnt <= idle_next;
                if (timed_out) begin
                    state     <= IDLE;
                    sigout    <= 1'b0;
                    armed     <= 1'b0;
                    no_signal <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_zero_cross_slicer.sv
// tb_zero_cross_slicer: directed and randomized stimulus for zero_cross_slicer,
// checked cycle by cycle against a timestamp-based reference model.
module tb_zero_cross_slicer;

    localparam int HYST_TB    = 256;
    localparam int HOLDOFF_TB = 8;
    localparam int TIMEOUT_TB = 3000;
    localparam int CNT_MAX    = 20'hFFFFF;

    logic               CLK = 1'b0;
    logic               RSTb;
    logic signed [15:0] sample_in;
    logic               sample_valid;
    logic               sigout;
    logic [19:0]        period;
    logic               period_valid;
    logic               no_signal;

    int checks = 0;
    int errors = 0;

    // Reference model: level plus timestamps of the last transition / rise.
    int cyc = 0;
    bit m_active;
    bit m_level;
    bit m_armed;
    bit m_pv;
    bit m_nosig;
    int m_period;
    int m_nvalid;
    int m_last_trans;
    int m_last_rise;

    int strobes[$];
    int strobe_at[$];
    int bad_changes;

    zero_cross_slicer #(
        .HYST    (16'(HYST_TB)),
        .HOLDOFF (HOLDOFF_TB),
        .TIMEOUT (20'(TIMEOUT_TB))
    ) dut (
        .CLK          (CLK),
        .RSTb         (RSTb),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sigout       (sigout),
        .period       (period),
        .period_valid (period_valid),
        .no_signal    (no_signal)
    );

    always #5 CLK = ~CLK;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    // Apply the behavioural rules for one clock edge with the sampled inputs.
    function automatic void model_step(input int s, input bit v, input bit r);
        bit up;
        bit dn;
        bit free_to_move;
        bit moved;
        if (!r) begin
            m_active     = 0;
            m_level      = 0;
            m_armed      = 0;
            m_pv         = 0;
            m_nosig      = 1;
            m_period     = 0;
            m_nvalid     = HOLDOFF_TB;
            m_last_trans = cyc;
            m_last_rise  = cyc;
            return;
        end
        m_pv         = 0;
        up           = v && (s > HYST_TB);
        dn           = v && (s < -HYST_TB);
        free_to_move = (m_nvalid >= HOLDOFF_TB);
        moved        = 0;
        if (!m_active) begin
            if (up) begin
                m_active    = 1;
                m_level     = 1;
                m_armed     = 1;
                m_last_rise = cyc;
                moved       = 1;
            end else if (dn) begin
                m_active = 1;
                m_level  = 0;
                moved    = 1;
            end
        end else if (m_level && dn && free_to_move) begin
            m_level = 0;
            moved   = 1;
        end else if (!m_level && up && free_to_move) begin
            if (m_armed) begin
                m_period = (cyc - m_last_rise > CNT_MAX) ? CNT_MAX : cyc - m_last_rise;
                m_pv     = 1;
            end
            m_armed     = 1;
            m_last_rise = cyc;
            m_level     = 1;
            moved       = 1;
        end
        if (moved) begin
            m_last_trans = cyc;
            m_nvalid     = 0;
            m_nosig      = 0;
        end else begin
            if (v) m_nvalid++;
            if (cyc - m_last_trans >= TIMEOUT_TB) begin
                m_active = 0;
                m_level  = 0;
                m_armed  = 0;
                m_nosig  = 1;
            end
        end
    endfunction

    // One clock: drive inputs, step the model on the edge, compare #1 later.
    task automatic tick(input logic signed [15:0] s, input logic v, input logic r);
        logic prev_sig;
        int   si;
        sample_in    = s;
        sample_valid = v;
        RSTb         = r;
        si           = s;
        prev_sig     = sigout;
        @(posedge CLK);
        cyc++;
        model_step(si, v, r);
        #1;
        check("sigout", sigout, m_active && m_level);
        check("period", period, m_period);
        check("period_valid", period_valid, m_pv);
        check("no_signal", no_signal, m_nosig);
        if (period_valid === 1'b1) begin
            strobes.push_back(int'(period));
            strobe_at.push_back(cyc);
        end
        if (r && !v && (sigout !== prev_sig)) bad_changes++;
    endtask

    function automatic int tri_wave(input int t);
        int ph;
        ph = t % 2500;
        if (ph < 1250) return -1000 + (ph * 8) / 5;
        return 1000 - ((ph - 1250) * 8) / 5;
    endfunction

    initial begin
        int t0;
        int s;
        RSTb         = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;

        // Reset state.
        repeat (3) tick(16'sd0, 1'b0, 1'b0);
        check("rst_sigout", sigout, 0);
        check("rst_period", period, 0);
        check("rst_period_valid", period_valid, 0);
        check("rst_no_signal", no_signal, 1);

        // Square wave toggling every 1000 clocks, valid every cycle.
        strobes.delete();
        strobe_at.delete();
        t0 = cyc + 1;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 1000; i++) begin
                tick(16'sd1000, 1'b1, 1'b1);
                if (p == 0 && i == 0) check("s1_rise_latency", sigout, 1);
            end
            for (int i = 0; i < 1000; i++) begin
                tick(-16'sd1000, 1'b1, 1'b1);
                if (p == 0 && i == 0) check("s1_fall_latency", sigout, 0);
            end
        end
        check("s1_strobe_count", strobes.size(), 2);
        if (strobes.size() >= 2) begin
            check("s1_first_strobe_at", strobe_at[0] - t0, 2000);
            check("s1_period_first", strobes[0], 2000);
            check("s1_period_second", strobes[1], 2000);
        end

        // Samples exactly at +/-HYST never move the slicer.
        tick(16'sd0, 1'b0, 1'b0);
        repeat (5) tick(16'sd256, 1'b1, 1'b1);
        repeat (5) tick(-16'sd256, 1'b1, 1'b1);
        check("s2_edge_sigout", sigout, 0);
        check("s2_edge_no_signal", no_signal, 1);

        // Holdoff: spike on sample 3 ignored, crossing on sample 9 taken.
        tick(-16'sd1000, 1'b1, 1'b1);
        check("s3_idle_to_low_sigout", sigout, 0);
        check("s3_idle_to_low_no_signal", no_signal, 0);
        repeat (20) tick(-16'sd1000, 1'b1, 1'b1);
        tick(16'sd1000, 1'b1, 1'b1);
        check("s3_rise", sigout, 1);
        repeat (2) tick(16'sd1000, 1'b1, 1'b1);
        tick(-16'sd1000, 1'b1, 1'b1);
        check("s3_spike_ignored", sigout, 1);
        repeat (5) tick(16'sd1000, 1'b1, 1'b1);
        tick(-16'sd1000, 1'b1, 1'b1);
        check("s3_fall_after_holdoff", sigout, 0);

        // Timeout after the last transition, then recovery without strobe.
        repeat (8) tick(-16'sd1000, 1'b1, 1'b1);
        tick(16'sd1000, 1'b1, 1'b1);
        check("s4_rise_sigout", sigout, 1);
        check("s4_rise_period", period, 18);
        repeat (TIMEOUT_TB - 1) tick(16'sd1000, 1'b1, 1'b1);
        check("s4_pre_timeout_no_signal", no_signal, 0);
        check("s4_pre_timeout_sigout", sigout, 1);
        tick(16'sd1000, 1'b1, 1'b1);
        check("s4_timeout_no_signal", no_signal, 1);
        check("s4_timeout_sigout", sigout, 0);
        check("s4_timeout_period_held", period, 18);
        tick(-16'sd1000, 1'b1, 1'b1);
        check("s4_recover_no_signal", no_signal, 0);
        check("s4_recover_sigout", sigout, 0);
        repeat (8) tick(-16'sd1000, 1'b1, 1'b1);
        tick(16'sd1000, 1'b1, 1'b1);
        check("s4_first_rise_no_strobe", period_valid, 0);
        check("s4_first_rise_sigout", sigout, 1);

        // Reset pulse on the cycle of a pending rising transition.
        repeat (8) tick(16'sd1000, 1'b1, 1'b1);
        tick(-16'sd1000, 1'b1, 1'b1);
        repeat (8) tick(-16'sd1000, 1'b1, 1'b1);
        tick(16'sd1000, 1'b1, 1'b0);
        check("s5_rst_sigout", sigout, 0);
        check("s5_rst_period", period, 0);
        check("s5_rst_period_valid", period_valid, 0);
        check("s5_rst_no_signal", no_signal, 1);
        tick(16'sd1000, 1'b1, 1'b1);
        check("s5_post_rst_rise_no_strobe", period_valid, 0);
        check("s5_post_rst_rise_sigout", sigout, 1);
        repeat (8) tick(16'sd1000, 1'b1, 1'b1);
        tick(-16'sd1000, 1'b1, 1'b1);
        repeat (8) tick(-16'sd1000, 1'b1, 1'b1);
        tick(16'sd1000, 1'b1, 1'b1);
        check("s5_second_rise_strobe", period_valid, 1);
        check("s5_second_rise_period", period, 18);

        // 40 kHz-equivalent triangle tone, valid every 4 clocks.
        tick(16'sd0, 1'b0, 1'b0);
        strobes.delete();
        strobe_at.delete();
        bad_changes = 0;
        for (int t = 0; t < 10000; t++) begin
            tick(16'(tri_wave(t)), ((t % 4) == 0), 1'b1);
        end
        check("s6_strobe_count", strobes.size(), 3);
        foreach (strobes[i]) begin
            check("s6_period_in_range", (strobes[i] >= 2496) && (strobes[i] <= 2504), 1);
        end
        check("s6_changes_on_valid_only", bad_changes, 0);

        // Randomized samples, valid and occasional reset against the model.
        for (int i = 0; i < 4000; i++) begin
            s = int'($urandom_range(0, 2400)) - 1200;
            tick(16'(s), 1'($urandom_range(0, 1)), ($urandom_range(0, 999) != 0));
        end
        // Random samples inside the hysteresis band until loss of signal.
        for (int i = 0; i < TIMEOUT_TB + 50; i++) begin
            s = int'($urandom_range(0, 512)) - 256;
            tick(16'(s), 1'($urandom_range(0, 1)), 1'b1);
        end
        check("s7_quiet_no_signal", no_signal, 1);
        check("s7_quiet_sigout", sigout, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
